// File: rtl/dii_packet_rx.sv
// dii_packet_rx
//   Slave-side end of a DII channel. Collects one first/last-framed packet of
//   16-bit flits into a word buffer and holds it as a flat word array with a
//   word count until the consumer takes it.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_data         DII flit data
//   in_first        flit is first of packet
//   in_last         flit is last of packet
//   in_valid        flit valid
//   in_ready        flit accepted when in_valid & in_ready
//   out_words       packet words, word k at [16k+15:16k]; word 0 = dest
//   out_size        number of valid words in out_words (1..MAX_WORDS)
//   out_valid       complete packet held
//   out_ready       consumer takes packet when out_valid & out_ready
//   err_framing     1-cycle pulse: framing violation
//   err_overflow    1-cycle pulse: over-long packet dropped
module dii_packet_rx #(
   parameter int unsigned MAX_WORDS = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [15:0]                        in_data,
   input  logic                               in_first,
   input  logic                               in_last,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic [16*MAX_WORDS-1:0]            out_words,
   output logic [$clog2(MAX_WORDS+1)-1:0]     out_size,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               err_framing,
   output logic                               err_overflow
);

   localparam int unsigned SW = $clog2(MAX_WORDS + 1);

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      DROP,
      DONE
   } state_t;

   state_t                        state_q, state_d;
   logic [MAX_WORDS-1:0][15:0]    words_q, words_d;
   logic [SW-1:0]                 size_q, size_d;
   logic [SW-1:0]                 idx_q, idx_d;
   logic                          rdy_en_q;
   logic                          err_framing_q, err_framing_d;
   logic                          err_overflow_q, err_overflow_d;
   logic                          accept;

   // rdy_en_q keeps in_ready low through reset and until the first clock edge
   // after reset is released.
   assign in_ready     = rdy_en_q & (state_q != DONE);
   assign accept       = in_valid & in_ready;
   assign out_valid    = (state_q == DONE);
   assign out_words    = words_q;
   assign out_size     = size_q;
   assign err_framing  = err_framing_q;
   assign err_overflow = err_overflow_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         words_q        <= '0;
         size_q         <= '0;
         idx_q          <= '0;
         rdy_en_q       <= 1'b0;
         err_framing_q  <= 1'b0;
         err_overflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         words_q        <= words_d;
         size_q         <= size_d;
         idx_q          <= idx_d;
         rdy_en_q       <= 1'b1;
         err_framing_q  <= err_framing_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      words_d        = words_q;
      size_d         = size_q;
      idx_d          = idx_q;
      err_framing_d  = 1'b0;
      err_overflow_d = 1'b0;

      case (state_q)
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: begin
            if (accept) begin
               if (in_first) begin
                  // A first flit always starts a fresh packet. Only an
                  // interrupted RECV is a framing error; DROP already
                  // reported its overflow.
                  err_framing_d = (state_q == RECV);
                  words_d       = '0;
                  words_d[0]    = in_data;
                  idx_d         = SW'(1);
                  if (in_last) begin
                     size_d  = SW'(1);
                     state_d = DONE;
                  end else begin
                     state_d = RECV;
                  end
               end else begin
                  case (state_q)
                     IDLE: err_framing_d = 1'b1;
                     RECV: begin
                        if (idx_q < SW'(MAX_WORDS)) begin
                           for (int unsigned k = 0; k < MAX_WORDS; k++) begin
                              if (SW'(k) == idx_q) words_d[k] = in_data;
                           end
                           idx_d = idx_q + SW'(1);
                           if (in_last) begin
                              size_d  = idx_q + SW'(1);
                              state_d = DONE;
                           end
                        end else begin
                           // Overflow on the last flit has nothing left to drop.
                           err_overflow_d = 1'b1;
                           state_d        = in_last ? IDLE : DROP;
                        end
                     end
                     DROP: begin
                        if (in_last) state_d = IDLE;
                     end
                     default: ;
                  endcase
               end
            end
         end
      endcase
   end

endmodule

// File: tb/tb_dii_packet_rx.sv
// tb_dii_packet_rx
//   Directed and randomized stimulus for dii_packet_rx, checked each cycle
//   against a packet-level reference model built on a word queue.
module tb_dii_packet_rx;

   localparam int unsigned MAXW = 8;
   localparam int unsigned SW   = $clog2(MAXW + 1);

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [15:0]           in_data = '0;
   logic                  in_first = 1'b0;
   logic                  in_last = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [16*MAXW-1:0]    out_words;
   logic [SW-1:0]         out_size;
   logic                  out_valid;
   logic                  out_ready = 1'b0;
   logic                  err_framing;
   logic                  err_overflow;

   dii_packet_rx #(.MAX_WORDS(MAXW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_first     (in_first),
      .in_last      (in_last),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_words    (out_words),
      .out_size     (out_size),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .err_framing  (err_framing),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   // Reference model: packet under construction, packet on offer, and flags.
   logic [15:0] m_cur[$];
   logic [15:0] m_out[$];
   bit          m_held   = 1'b0;
   bit          m_in_pkt = 1'b0;
   bit          m_drop   = 1'b0;
   bit          m_rdy_en = 1'b0;

   logic [15:0] pk[$];

   task automatic chk(input string tag, input logic [16*MAXW-1:0] obs, input logic [16*MAXW-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [16*MAXW-1:0] flat(input logic [15:0] q[$]);
      logic [16*MAXW-1:0] r = '0;
      foreach (q[i]) r[16*i +: 16] = q[i];
      return r;
   endfunction

   task automatic model_reset();
      m_cur.delete();
      m_out.delete();
      m_held   = 1'b0;
      m_in_pkt = 1'b0;
      m_drop   = 1'b0;
      m_rdy_en = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_ready"}, in_ready, 0);
      chk({tag, "_size"}, out_size, 0);
      chk({tag, "_words"}, out_words, 0);
      chk({tag, "_errf"}, err_framing, 0);
      chk({tag, "_erro"}, err_overflow, 0);
   endtask

   // One clock cycle: drive inputs, advance the model, then compare after the edge.
   task automatic step(input logic [15:0] d, input bit f, input bit l, input bit v,
                       input bit orr, output bit acc);
      bit fr = 1'b0;
      bit ov = 1'b0;
      in_data = d; in_first = f; in_last = l; in_valid = v; out_ready = orr;
      acc = v && m_rdy_en && !m_held;
      if (m_held && orr) begin
         m_held = 1'b0;
      end else if (acc) begin
         if (f) begin
            fr = m_in_pkt && !m_drop;
            m_cur.delete();
            m_cur.push_back(d);
            m_in_pkt = 1'b1;
            m_drop   = 1'b0;
         end else if (!m_in_pkt) begin
            fr = 1'b1;
         end else if (m_drop) begin
            if (l) begin m_in_pkt = 1'b0; m_drop = 1'b0; end
         end else if (m_cur.size() < MAXW) begin
            m_cur.push_back(d);
         end else begin
            ov = 1'b1;
            if (l) m_in_pkt = 1'b0;
            else   m_drop   = 1'b1;
         end
         if (l && m_in_pkt && !m_drop) begin
            m_out    = m_cur;
            m_held   = 1'b1;
            m_in_pkt = 1'b0;
         end
      end
      m_rdy_en = 1'b1;
      @(posedge clk); #1;
      chk("err_framing", err_framing, fr);
      chk("err_overflow", err_overflow, ov);
      chk("out_valid", out_valid, m_held);
      chk("in_ready", in_ready, m_rdy_en && !m_held);
      if (m_held) begin
         chk("out_size", out_size, m_out.size());
         chk("out_words", out_words, flat(m_out));
      end
   endtask

   task automatic idle(input int unsigned n, input bit orr);
      bit acc;
      for (int unsigned i = 0; i < n; i++) step(16'($urandom), 1'b0, 1'b0, 1'b0, orr, acc);
   endtask

   // orr_mode: 0 = out_ready high, 1 = out_ready low, 2 = random with random gaps.
   task automatic send(input bit with_first, input bit with_last, input int unsigned orr_mode);
      for (int i = 0; i < pk.size(); i++) begin
         bit acc = 1'b0;
         int unsigned tries = 0;
         while (!acc && tries < 60) begin
            bit orr = (orr_mode == 0) ? 1'b1 : (orr_mode == 1) ? 1'b0 : bit'($urandom_range(0, 1));
            if (orr_mode == 2 && $urandom_range(0, 3) == 0) idle(1, orr);
            step(pk[i], with_first && (i == 0), with_last && (i == pk.size() - 1), 1'b1, orr, acc);
            tries++;
         end
         if (!acc) chk("accept_timeout", acc, 1);
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      check_reset_outputs(tag);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk({tag, "_ready_after_release"}, in_ready, 0);
   endtask

   initial begin
      bit acc;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_reset_outputs("reset");
      rst = 1'b0;
      #1;
      chk("ready_before_first_edge", in_ready, 0);

      // 1: 4-flit packet, consumer always ready
      pk = '{16'h0010, 16'h0020, 16'h4000, 16'hBEEF};
      send(1'b1, 1'b1, 0);
      idle(2, 1'b1);

      // 2: single flit, consumer stalls 5 cycles
      pk = '{16'h0005};
      send(1'b1, 1'b1, 1);
      idle(5, 1'b0);
      idle(2, 1'b1);

      // 3: 10-flit packet overflows, then a 2-flit packet
      pk.delete();
      for (int i = 0; i < 10; i++) pk.push_back(16'(16'h0100 + i));
      send(1'b1, 1'b1, 0);
      pk = '{16'h0C01, 16'h0C02};
      send(1'b1, 1'b1, 0);
      idle(2, 1'b1);

      // 4: unterminated packet interrupted by a new first
      pk = '{16'h000A, 16'h000B};
      send(1'b1, 1'b0, 0);
      pk = '{16'h0001, 16'h0002};
      send(1'b1, 1'b1, 0);
      idle(2, 1'b1);

      // 5: stray flit in IDLE, then a normal packet
      step(16'h0077, 1'b0, 1'b0, 1'b1, 1'b1, acc);
      pk = '{16'h0D01, 16'h0D02, 16'h0D03};
      send(1'b1, 1'b1, 0);
      idle(2, 1'b1);

      // 6: reset mid-packet, reset while holding, then a full packet
      pk = '{16'h0E01, 16'h0E02};
      send(1'b1, 1'b0, 0);
      do_reset("rst_recv");
      pk = '{16'h0F01, 16'h0F02, 16'h0F03};
      send(1'b1, 1'b1, 1);
      do_reset("rst_done");
      pk = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
      send(1'b1, 1'b1, 0);
      idle(2, 1'b1);

      // Randomized packets with occasional framing faults and overlong lengths
      for (int p = 0; p < 60; p++) begin
         int unsigned len = $urandom_range(1, 11);
         pk.delete();
         for (int unsigned i = 0; i < len; i++) pk.push_back(16'($urandom));
         send($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, 2);
      end
      idle(3, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
